// File: rtl/vga_cmd_sched_if.sv
// Command handshake between a CPU-side master and the VGA command scheduler.
interface vga_cmd_sched_if #(
  parameter int V_W = 4,
  parameter int H_W = 5
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [V_W-1:0] cmd_v;
  logic [H_W-1:0] cmd_h;
  logic [31:0]    cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_v, cmd_h, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_v, cmd_h, cmd_data, output cmd_ready);
endinterface

// File: rtl/vga_cmd_sched.sv
// Buffers CPU commands and turns them into single-cycle character-cell writes
// (single write, full-screen clear, row fill) for the VGA controller write port.
//
// state | meaning
// IDLE  | waiting for a command; pops the FIFO head when one is present
// ISSUE | holding one WRITE until wr_allow lets it out
// FILL  | walking the cursor row-major up to the last cell of a CLEAR/FILL_ROW
module vga_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROWS       = 16,
  parameter int COLS       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  vga_cmd_sched_if.slave                cmd,
  input  logic                          wr_allow,
  output logic [$clog2(ROWS)-1:0]       vga_addr_v,
  output logic [$clog2(COLS)-1:0]       vga_addr_h,
  output logic [31:0]                   vga_ctrl,
  output logic                          vga_ctrl_en,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int VW = $clog2(ROWS);
  localparam int HW = $clog2(COLS);
  localparam logic [VW-1:0] LAST_ROW = VW'(ROWS - 1);
  localparam logic [HW-1:0] LAST_COL = HW'(COLS - 1);
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  typedef struct packed {
    logic [1:0]    op;
    logic [VW-1:0] v;
    logic [HW-1:0] h;
    logic [31:0]   data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, FILL} state_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  entry_t        incoming;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   level;
  logic          push, pop;

  state_t        state;
  logic [VW-1:0] cur_v, last_v;
  logic [HW-1:0] cur_h;
  logic [31:0]   data;

  assign incoming      = '{op: cmd.cmd_op, v: cmd.cmd_v, h: cmd.cmd_h, data: cmd.cmd_data};
  assign head          = mem[rd_ptr];
  assign cmd.cmd_ready = (level != (PW+1)'(FIFO_DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready && !flush;
  assign pop           = (state == IDLE) && (level != '0) && !flush;
  assign busy          = (level != '0) || (state != IDLE);
  assign fifo_level    = level;

  // Storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= incoming;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_v       <= '0;
      cur_h       <= '0;
      last_v      <= '0;
      data        <= '0;
      vga_addr_v  <= '0;
      vga_addr_h  <= '0;
      vga_ctrl    <= '0;
      vga_ctrl_en <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      vga_ctrl_en <= 1'b0;
    end else begin
      vga_ctrl_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            data <= head.data;
            case (head.op)
              OP_WRITE: begin
                cur_v <= head.v;
                cur_h <= head.h;
                state <= ISSUE;
              end
              OP_CLEAR: begin
                cur_v  <= '0;
                cur_h  <= '0;
                last_v <= LAST_ROW;
                state  <= FILL;
              end
              OP_FILL: begin
                cur_v  <= head.v;
                cur_h  <= '0;
                last_v <= head.v;
                state  <= FILL;
              end
              default: state <= IDLE;
            endcase
          end
        end
        ISSUE: begin
          if (wr_allow) begin
            vga_addr_v  <= cur_v;
            vga_addr_h  <= cur_h;
            vga_ctrl    <= data;
            vga_ctrl_en <= 1'b1;
            state       <= IDLE;
          end
        end
        FILL: begin
          if (wr_allow) begin
            vga_addr_v  <= cur_v;
            vga_addr_h  <= cur_h;
            vga_ctrl    <= data;
            vga_ctrl_en <= 1'b1;
            if (cur_v == last_v && cur_h == LAST_COL) begin
              state <= IDLE;
            end else if (cur_h == LAST_COL) begin
              cur_h <= '0;
              cur_v <= cur_v + VW'(1);
            end else begin
              cur_h <= cur_h + HW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_cmd_sched.sv
// Directed bench for vga_cmd_sched: write, clear, row fill, back-pressure, flush and async reset.
module tb_vga_cmd_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_allow = 1'b0;
  logic [3:0]  vga_addr_v;
  logic [4:0]  vga_addr_h;
  logic [31:0] vga_ctrl;
  logic        vga_ctrl_en;
  logic        busy;
  logic [2:0]  fifo_level;

  vga_cmd_sched_if cmd_if ();

  vga_cmd_sched dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cmd         (cmd_if),
    .wr_allow    (wr_allow),
    .vga_addr_v  (vga_addr_v),
    .vga_addr_h  (vga_addr_h),
    .vga_ctrl    (vga_ctrl),
    .vga_ctrl_en (vga_ctrl_en),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        allow;
    logic [3:0]  v;
    logic [4:0]  h;
    logic [31:0] d;
  } strobe_t;

  strobe_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log any strobe with the wr_allow that drove its edge.
  task automatic cyc();
    strobe_t s;
    s.allow = wr_allow;
    @(negedge clk);
    if (vga_ctrl_en) begin
      s.v = vga_addr_v;
      s.h = vga_addr_h;
      s.d = vga_ctrl;
      q.push_back(s);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] v, input logic [4:0] h,
                      input logic [31:0] d);
    logic accepted;
    accepted = 1'b0;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_v     = v;
    cmd_if.cmd_h     = h;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (cmd_if.cmd_ready) begin
        cyc();
        accepted = 1'b1;
        break;
      end
      cyc();
    end
    cmd_if.cmd_valid = 1'b0;
    check("push_accept", accepted, 1);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int k = 0; k < bound && busy; k++) cyc();
    check(tag, busy, 0);
  endtask

  initial begin
    int bad, viol, n0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_v     = '0;
    cmd_if.cmd_h     = '0;
    cmd_if.cmd_data  = '0;

    // 1: reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc();
    check("rst_en", vga_ctrl_en, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ctrl", {vga_addr_v, vga_addr_h, vga_ctrl}, 0);

    // 2: single WRITE, strobe in the cycle after handshake edge + 2
    wr_allow = 1'b1;
    push(2'b00, 4'd3, 5'd17, 32'h0000_0141);
    check("wr_lat0", vga_ctrl_en, 0);
    cyc();
    check("wr_lat1", vga_ctrl_en, 0);
    cyc();
    check("wr_strobe", vga_ctrl_en, 1);
    check("wr_cell", {vga_addr_v, vga_addr_h, vga_ctrl}, {4'd3, 5'd17, 32'h141});
    cyc();
    check("wr_single", vga_ctrl_en, 0);
    check("wr_busy", busy, 0);

    // 3: back-pressure; first command goes straight to the executor, next four fill the FIFO
    q.delete();
    wr_allow = 1'b0;
    for (int i = 0; i < 5; i++) push(2'b00, 4'(i), 5'(10 + i), 32'h100 + i);
    check("bp_level", fifo_level, 4);
    check("bp_ready", cmd_if.cmd_ready, 0);
    cmd_if.cmd_op = 2'b00; cmd_if.cmd_v = 4'd5; cmd_if.cmd_h = 5'd15;
    cmd_if.cmd_data = 32'h105; cmd_if.cmd_valid = 1'b1;
    repeat (3) cyc();
    check("bp_hold_level", fifo_level, 4);
    check("bp_no_strobe", q.size(), 0);
    wr_allow = 1'b1;
    push(2'b00, 4'd5, 5'd15, 32'h105);
    drain("bp_drain", 100);
    check("bp_count", q.size(), 6);
    bad = 0;
    foreach (q[i])
      if (q[i].v !== 4'(i) || q[i].h !== 5'(10 + i) || q[i].d !== 32'h100 + i) bad++;
    check("bp_order", bad, 0);

    // 4: CLEAR with wr_allow toggling every 7 cycles
    q.delete();
    push(2'b01, 4'd0, 5'd0, 32'h20);
    for (int c = 0; c < 3000 && busy; c++) begin
      wr_allow = ((c / 7) % 2) == 0;
      cyc();
    end
    check("clr_done", busy, 0);
    wr_allow = 1'b1;
    check("clr_count", q.size(), 512);
    bad = 0;
    viol = 0;
    foreach (q[i]) begin
      if (!q[i].allow) viol++;
      if (q[i].v !== 4'(i / 32) || q[i].h !== 5'(i % 32) || q[i].d !== 32'h20) bad++;
    end
    check("clr_gated", viol, 0);
    check("clr_order", bad, 0);

    // 5: FILL_ROW on the last row, then a plain WRITE
    q.delete();
    push(2'b10, 4'd15, 5'd9, 32'h2D);
    drain("fill_done", 200);
    check("fill_count", q.size(), 32);
    bad = 0;
    foreach (q[i]) if (q[i].v !== 4'd15 || q[i].h !== 5'(i) || q[i].d !== 32'h2D) bad++;
    check("fill_order", bad, 0);
    q.delete();
    push(2'b00, 4'd7, 5'd4, 32'hABCD);
    drain("fw_done", 20);
    check("fw_count", q.size(), 1);
    if (q.size() > 0) check("fw_cell", q[0], {1'b1, 4'd7, 5'd4, 32'hABCD});

    // reserved op is consumed silently
    q.delete();
    push(2'b11, 4'd1, 5'd1, 32'h1);
    drain("rsv_done", 20);
    check("rsv_none", q.size(), 0);

    // 6: flush during CLEAR at cell (2,5) with two queued writes
    push(2'b01, 4'd0, 5'd0, 32'h55);
    push(2'b00, 4'd1, 5'd2, 32'h77);
    push(2'b00, 4'd2, 5'd3, 32'h88);
    for (int k = 0; k < 300; k++) begin
      if (vga_ctrl_en && vga_addr_v == 4'd2 && vga_addr_h == 5'd5) break;
      cyc();
    end
    check("fl_at_cell", {vga_ctrl_en, vga_addr_v, vga_addr_h}, {1'b1, 4'd2, 5'd5});
    check("fl_pre_level", fifo_level, 2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("fl_en", vga_ctrl_en, 0);
    check("fl_level", fifo_level, 0);
    check("fl_busy", busy, 0);
    n0 = q.size();
    repeat (10) cyc();
    check("fl_quiet", q.size(), n0);
    // push coinciding with flush is dropped
    cmd_if.cmd_op = 2'b00; cmd_if.cmd_v = 4'd9; cmd_if.cmd_h = 5'd9;
    cmd_if.cmd_data = 32'h99; cmd_if.cmd_valid = 1'b1; flush = 1'b1;
    cyc();
    cmd_if.cmd_valid = 1'b0; flush = 1'b0;
    check("fl_push_level", fifo_level, 0);
    repeat (5) cyc();
    check("fl_push_quiet", q.size(), n0);

    // rst asserted mid-FILL clears outputs without waiting for a clock
    push(2'b10, 4'd1, 5'd0, 32'hFFFF_FFFF);
    repeat (4) cyc();
    check("rf_active", vga_ctrl_en, 1);
    #2 rst = 1'b1;
    #1;
    check("rf_en", vga_ctrl_en, 0);
    check("rf_outs", {vga_addr_v, vga_addr_h, vga_ctrl}, 0);
    check("rf_busy", busy, 0);
    check("rf_level", fifo_level, 0);
    q.delete();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (40) cyc();
    check("rf_quiet", q.size(), 0);
    check("rf_ready", cmd_if.cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
